hovalaag_io_bridge: RTL and testbench

Host-side I/O bridge for the Hovalaag CPU, acting as the far end of its IN1/IN2 and OUT stream interface. Buffers host-written input words in two show-ahead FIFOs presented on IN1/IN2 and popped by the CPU's IN1_adv/IN2_adv. Captures every OUT_valid word with its OUT_select tag into an order-preserving output FIFO drained by the host via valid/ready. Flags underflow and overflow stickily, so a test harness can run CPU programs against queued input vectors.

---
 rtl/hovalaag_io_pkg.sv | 16 +
 rtl/hovalaag_fifo.sv | 55 +++++
 rtl/hovalaag_io_bridge.sv | 86 ++++++++
 tb/tb_hovalaag_io_bridge.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hovalaag_io_pkg.sv
// Shared types and constants for the Hovalaag host I/O bridge.
package hovalaag_io_pkg;

  localparam int WORD_W = 12;

  localparam logic CH_IN1  = 1'b0;
  localparam logic CH_IN2  = 1'b1;
  localparam logic CH_OUT1 = 1'b0;
  localparam logic CH_OUT2 = 1'b1;

  typedef struct packed {
    logic              sel;
    logic [WORD_W-1:0] data;
  } out_word_t;

endpackage

// File: rtl/hovalaag_fifo.sv
// Show-ahead synchronous FIFO; pops on empty are ignored and empty reads return zero.
module hovalaag_fifo #(
  parameter int WIDTH      = 12,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_pop_ok;
  logic                  w_push_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_data    = o_empty ? '0 : r_mem[r_rptr];
  assign w_pop_ok  = i_pop && !o_empty;
  // A full FIFO can still take a write when its head leaves on the same edge.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + DEPTH_LOG2'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + DEPTH_LOG2'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hovalaag_io_bridge.sv
// Host-side bridge: two input FIFOs feeding the CPU IN ports, one tagged output FIFO.
module hovalaag_io_bridge
  import hovalaag_io_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [11:0]         in_data,
  input  logic                in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [11:0]         IN1,
  input  logic                IN1_adv,
  output logic [11:0]         IN2,
  input  logic                IN2_adv,
  input  logic [11:0]         OUT,
  input  logic                OUT_valid,
  input  logic                OUT_select,
  output logic [11:0]         out_data,
  output logic                out_sel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DEPTH_LOG2:0] in1_count,
  output logic [DEPTH_LOG2:0] in2_count,
  output logic [DEPTH_LOG2:0] out_count,
  output logic                err_underflow1,
  output logic                err_underflow2,
  output logic                err_overflow,
  input  logic                err_clr
);

  logic      w_in1_full, w_in1_empty, w_in2_full, w_in2_empty;
  logic      w_out_full, w_out_empty;
  logic      w_push1, w_push2, w_out_pop, w_out_drop;
  out_word_t w_out_wr, w_out_rd;

  logic r_err_underflow1, r_err_underflow2, r_err_overflow;

  assign in_ready   = (in_sel == CH_IN2) ? !w_in2_full : !w_in1_full;
  assign w_push1    = in_valid && in_ready && (in_sel == CH_IN1);
  assign w_push2    = in_valid && in_ready && (in_sel == CH_IN2);

  assign out_valid  = !w_out_empty;
  assign w_out_pop  = out_valid && out_ready;
  assign w_out_drop = OUT_valid && w_out_full && !w_out_pop;
  assign w_out_wr   = '{sel: OUT_select, data: OUT};
  assign out_data   = w_out_rd.data;
  assign out_sel    = w_out_rd.sel;

  hovalaag_fifo #(.WIDTH(WORD_W), .DEPTH_LOG2(DEPTH_LOG2)) u_in1 (
    .clk(clk), .rst_n(rst_n), .i_push(w_push1), .i_data(in_data), .i_pop(IN1_adv),
    .o_data(IN1), .o_full(w_in1_full), .o_empty(w_in1_empty), .o_count(in1_count)
  );

  hovalaag_fifo #(.WIDTH(WORD_W), .DEPTH_LOG2(DEPTH_LOG2)) u_in2 (
    .clk(clk), .rst_n(rst_n), .i_push(w_push2), .i_data(in_data), .i_pop(IN2_adv),
    .o_data(IN2), .o_full(w_in2_full), .o_empty(w_in2_empty), .o_count(in2_count)
  );

  hovalaag_fifo #(.WIDTH($bits(out_word_t)), .DEPTH_LOG2(DEPTH_LOG2)) u_out (
    .clk(clk), .rst_n(rst_n), .i_push(OUT_valid), .i_data(w_out_wr), .i_pop(w_out_pop),
    .o_data(w_out_rd), .o_full(w_out_full), .o_empty(w_out_empty), .o_count(out_count)
  );

  // New error events win over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_underflow1 <= 1'b0;
      r_err_underflow2 <= 1'b0;
      r_err_overflow   <= 1'b0;
    end else begin
      if (IN1_adv && w_in1_empty) r_err_underflow1 <= 1'b1;
      else if (err_clr)           r_err_underflow1 <= 1'b0;
      if (IN2_adv && w_in2_empty) r_err_underflow2 <= 1'b1;
      else if (err_clr)           r_err_underflow2 <= 1'b0;
      if (w_out_drop)             r_err_overflow   <= 1'b1;
      else if (err_clr)           r_err_overflow   <= 1'b0;
    end
  end

  assign err_underflow1 = r_err_underflow1;
  assign err_underflow2 = r_err_underflow2;
  assign err_overflow   = r_err_overflow;

endmodule

// File: tb/tb_hovalaag_io_bridge.sv
// Directed bench for hovalaag_io_bridge with immediate-assertion checks.
module tb_hovalaag_io_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] in_data;
  logic        in_sel, in_valid, in_ready;
  logic [11:0] IN1, IN2;
  logic        IN1_adv, IN2_adv;
  logic [11:0] OUT;
  logic        OUT_valid, OUT_select;
  logic [11:0] out_data;
  logic        out_sel, out_valid, out_ready;
  logic [4:0]  in1_count, in2_count, out_count;
  logic        err_underflow1, err_underflow2, err_overflow, err_clr;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hovalaag_io_bridge #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .IN1(IN1), .IN1_adv(IN1_adv), .IN2(IN2), .IN2_adv(IN2_adv),
    .OUT(OUT), .OUT_valid(OUT_valid), .OUT_select(OUT_select),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
    .in1_count(in1_count), .in2_count(in2_count), .out_count(out_count),
    .err_underflow1(err_underflow1), .err_underflow2(err_underflow2),
    .err_overflow(err_overflow), .err_clr(err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
    IN1_adv = 1'b0; IN2_adv = 1'b0; OUT = '0; OUT_valid = 1'b0; OUT_select = 1'b0;
    out_ready = 1'b0; err_clr = 1'b0;
    #2;
    chk("rst_in1_count", in1_count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_IN1", IN1, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic push to each channel, then pop IN1
    in_valid = 1'b1; in_sel = 1'b0; in_data = 12'h123;
    tick();
    in_sel = 1'b1; in_data = 12'hABC;
    tick();
    in_valid = 1'b0;
    chk("push_IN1", IN1, 12'h123);
    chk("push_IN2", IN2, 12'hABC);
    chk("push_in1_count", in1_count, 1);
    chk("push_in2_count", in2_count, 1);
    IN1_adv = 1'b1;
    #1;
    chk("adv_same_cycle_IN1", IN1, 12'h123);
    tick();
    IN1_adv = 1'b0;
    chk("pop_IN1", IN1, 12'h000);
    chk("pop_in1_count", in1_count, 0);
    chk("pop_IN2_kept", IN2, 12'hABC);
    IN2_adv = 1'b1;
    tick();
    IN2_adv = 1'b0;
    chk("pop_in2_count", in2_count, 0);

    // Fill IN1 and try a 17th push alongside a pop
    in_valid = 1'b1; in_sel = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_data = 12'h100 + 12'(i);
      tick();
    end
    chk("full_in1_count", in1_count, 16);
    chk("full_in_ready_sel0", in_ready, 0);
    in_sel = 1'b1;
    #1;
    chk("full_in_ready_sel1", in_ready, 1);
    in_sel = 1'b0; in_data = 12'hEEE; IN1_adv = 1'b1;
    #1;
    chk("full_head", IN1, 12'h100);
    tick();
    in_valid = 1'b0; IN1_adv = 1'b0;
    chk("refused_in1_count", in1_count, 15);
    chk("refused_head", IN1, 12'h101);
    chk("refused_in2_count", in2_count, 0);
    IN1_adv = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    IN1_adv = 1'b0;
    chk("drain_last", IN1, 12'h10F);
    IN1_adv = 1'b1;
    tick();
    IN1_adv = 1'b0;
    chk("drain_in1_count", in1_count, 0);
    chk("no_underflow1", err_underflow1, 0);

    // Underflow on IN2, clear, clear versus new underflow
    IN2_adv = 1'b1;
    tick();
    IN2_adv = 1'b0;
    chk("underflow2_set", err_underflow2, 1);
    chk("underflow2_count", in2_count, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("underflow2_clr", err_underflow2, 0);
    err_clr = 1'b1; IN2_adv = 1'b1;
    tick();
    err_clr = 1'b0; IN2_adv = 1'b0;
    chk("underflow2_set_wins", err_underflow2, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("underflow2_clr2", err_underflow2, 0);

    // Three back-to-back outputs, host always ready
    out_ready = 1'b1;
    OUT_valid = 1'b1; OUT_select = 1'b0; OUT = 12'h001;
    #1;
    chk("out_no_bypass", out_valid, 0);
    tick();
    chk("out0_valid", out_valid, 1);
    chk("out0_data", out_data, 12'h001);
    chk("out0_sel", out_sel, 0);
    OUT_select = 1'b1; OUT = 12'hFFF;
    tick();
    chk("out1_data", out_data, 12'hFFF);
    chk("out1_sel", out_sel, 1);
    chk("out1_count", out_count, 1);
    OUT_select = 1'b0; OUT = 12'h800;
    tick();
    OUT_valid = 1'b0;
    chk("out2_data", out_data, 12'h800);
    chk("out2_sel", out_sel, 0);
    tick();
    chk("out_drained", out_valid, 0);

    // Fill output FIFO, overflow, then accept-on-pop
    out_ready = 1'b0; OUT_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      OUT = 12'h200 + 12'(i); OUT_select = (i % 2) == 1;
      tick();
    end
    chk("ofull_count", out_count, 16);
    chk("ofull_no_err", err_overflow, 0);
    OUT = 12'h7AA; OUT_select = 1'b0;
    tick();
    OUT_valid = 1'b0;
    chk("overflow_set", err_overflow, 1);
    chk("overflow_count", out_count, 16);
    chk("overflow_head", out_data, 12'h200);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("overflow_clr", err_overflow, 0);
    OUT_valid = 1'b1; OUT = 12'h555; OUT_select = 1'b1; out_ready = 1'b1;
    tick();
    OUT_valid = 1'b0;
    chk("accept_pop_count", out_count, 16);
    chk("accept_pop_no_err", err_overflow, 0);
    chk("accept_pop_head", out_data, 12'h201);
    chk("accept_pop_head_sel", out_sel, 1);
    for (int i = 0; i < 15; i++) tick();
    chk("tail_data", out_data, 12'h555);
    chk("tail_sel", out_sel, 1);
    chk("tail_count", out_count, 1);
    tick();
    out_ready = 1'b0;
    chk("tail_empty", out_valid, 0);

    // Mid-stream asynchronous reset
    IN1_adv = 1'b1;
    tick();
    IN1_adv = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 12'h0AA;
    tick();
    in_sel = 1'b1; in_data = 12'h0BB;
    tick();
    in_valid = 1'b0; OUT_valid = 1'b1; OUT = 12'h333; OUT_select = 1'b0;
    tick();
    OUT_valid = 1'b0;
    chk("pre_rst_in1", in1_count, 1);
    chk("pre_rst_in2", in2_count, 1);
    chk("pre_rst_out", out_count, 1);
    chk("pre_rst_uf1", err_underflow1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in1_count", in1_count, 0);
    chk("arst_in2_count", in2_count, 0);
    chk("arst_out_count", out_count, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_uf1", err_underflow1, 0);
    chk("arst_IN1", IN1, 0);
    chk("arst_IN2", IN2, 0);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 12'h0F0;
    tick();
    in_valid = 1'b0;
    chk("post_rst_IN1", IN1, 12'h0F0);
    chk("post_rst_in1_count", in1_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
